mem_bus_master: RTL and testbench

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

---
 rtl/mem_bus_master_pkg.sv | 16 +
 rtl/mem_bus_master.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_master.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_master_pkg.sv
// Shared widths and FSM encoding for the memory bus master.
// Imported by the master RTL and by any bench that models the memory side.
package mem_bus_master_pkg;

    localparam int MBM_ADDR_W = 16;
    localparam int MBM_DATA_W = 16;
    localparam int MBM_LEN_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_READ     = 2'd1,
        ST_RD_DRAIN = 2'd2,
        ST_WRITE    = 2'd3
    } mbm_state_e;

endpackage

// File: rtl/mem_bus_master.sv
// Burst master for a shared-data-bus memory: takes read/write burst commands,
// issues registered memRead/memWrite strobes and returns read beats.
// Ports: clk, reset (sync, active-high); command cmdValid/cmdReady/cmdWrite/
// cmdAddr/cmdLen; write data wdValid/wdReady/wdData; read return rdValid/
// rdData; busy; memory side memRead/memWrite/addrBus and tristate dataBus.
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int ADDR_W = MBM_ADDR_W,
    parameter int DATA_W = MBM_DATA_W,
    parameter int LEN_W  = MBM_LEN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic              cmdWrite,
    input  logic [ADDR_W-1:0] cmdAddr,
    input  logic [LEN_W-1:0]  cmdLen,
    input  logic              wdValid,
    output logic              wdReady,
    input  logic [DATA_W-1:0] wdData,
    output logic              rdValid,
    output logic [DATA_W-1:0] rdData,
    output logic              busy,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] addrBus,
    inout  wire  [DATA_W-1:0] dataBus
);

    mbm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic cmd_fire;
    logic wd_fire;

    assign cmdReady = (state_q == ST_IDLE);
    assign busy     = ~cmdReady;
    // last_q marks the final write beat's strobe cycle: no more data taken.
    assign wdReady  = (state_q == ST_WRITE) && !last_q;
    assign cmd_fire = cmdValid && cmdReady;
    assign wd_fire  = wdValid && wdReady;

    assign memRead  = mem_rd_q;
    assign memWrite = mem_wr_q;
    assign addrBus  = addr_q;
    assign rdValid  = rd_valid_q;
    assign rdData   = rd_data_q;
    assign dataBus  = mem_wr_q ? wr_data_q : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            rd_pend_q  <= rd_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_d = cmdWrite ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (cnt_q == '0) begin
                    state_d = ST_RD_DRAIN;
                end
            end
            ST_RD_DRAIN: state_d = ST_IDLE;
            ST_WRITE: begin
                if (last_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        mem_rd_d  = 1'b0;
        mem_wr_d  = 1'b0;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        // Memory answers one cycle after it samples memRead; capture then.
        rd_pend_d  = mem_rd_q;
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_pend_q ? dataBus : rd_data_q;
        unique case (state_q)
            ST_IDLE: begin
                last_d = 1'b0;
                if (cmd_fire) begin
                    cnt_d = cmdLen;
                    if (cmdWrite) begin
                        ptr_d = cmdAddr;
                    end else begin
                        mem_rd_d = 1'b1;
                        addr_d   = cmdAddr;
                        ptr_d    = cmdAddr + ADDR_W'(1);
                    end
                end
            end
            ST_READ: begin
                if (cnt_q != '0) begin
                    mem_rd_d = 1'b1;
                    addr_d   = ptr_q;
                    ptr_d    = ptr_q + ADDR_W'(1);
                    cnt_d    = cnt_q - LEN_W'(1);
                end
            end
            ST_WRITE: begin
                if (wd_fire) begin
                    mem_wr_d  = 1'b1;
                    addr_d    = ptr_q;
                    ptr_d     = ptr_q + ADDR_W'(1);
                    wr_data_d = wdData;
                    if (cnt_q == '0) begin
                        last_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: table vectors, reset/abort sequences and random
// bursts against a word-array reference of what memory should contain.
module tb_mem_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmdValid, cmdWrite;
    logic [15:0] cmdAddr;
    logic [3:0]  cmdLen;
    logic        wdValid;
    logic [15:0] wdData;
    wire         cmdReady, wdReady, rdValid, busy, memRead, memWrite;
    wire  [15:0] rdData, addrBus;
    wire  [15:0] dataBus;

    logic        mem_drv = 1'b0;
    logic [15:0] mem_dq = '0;
    logic [15:0] mem [0:65535];
    logic [15:0] ref_mem [0:65535];

    int errors = 0;
    int checks = 0;

    int tcyc = 0;
    int last_rd_cyc = -1000;
    int min_gap = 1000;
    int bus_viol = 0;

    always #5 clk = ~clk;

    mem_bus_master #(.ADDR_W(16), .DATA_W(16), .LEN_W(4)) dut (
        .clk(clk), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
        .cmdAddr(cmdAddr), .cmdLen(cmdLen),
        .wdValid(wdValid), .wdReady(wdReady), .wdData(wdData),
        .rdValid(rdValid), .rdData(rdData), .busy(busy),
        .memRead(memRead), .memWrite(memWrite),
        .addrBus(addrBus), .dataBus(dataBus)
    );

    // Memory: samples strobes at the edge, drives read data the next cycle.
    assign dataBus = mem_drv ? mem_dq : 16'hzzzz;

    always @(posedge clk) begin
        if (memWrite) mem[addrBus] = dataBus;
        mem_drv <= memRead;
        if (memRead) mem_dq <= mem[addrBus];
    end

    always @(negedge clk) begin
        tcyc = tcyc + 1;
        if (memRead && memWrite) bus_viol = bus_viol + 1;
        if (memWrite && mem_drv) bus_viol = bus_viol + 1;
        if (memWrite && (tcyc - last_rd_cyc) < min_gap)
            min_gap = tcyc - last_rd_cyc;
        if (memRead) last_rd_cyc = tcyc;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_bubbles(input logic [31:0] m, input int beats);
        int z = 0;
        int b = 0;
        for (int k = 0; k < 32 && z < beats; k++) begin
            if (m[k]) b++;
            else z++;
        end
        return b;
    endfunction

    task automatic run_burst(input string tag, input bit wr,
                             input logic [15:0] addr, input logic [3:0] len,
                             input logic [31:0] bmask,
                             input logic [15:0] wbase, input logic [15:0] wstep,
                             input int exp_busy, input logic [15:0] exp_last);
        int beats, nr, nw, nrv, sent, k, cyc, w;
        int rd_cyc [16];
        logic [15:0] last_a, ea, ev;
        bit done;
        beats = int'(len) + 1;
        nr = 0; nw = 0; nrv = 0; sent = 0; k = 0; w = 0;
        done = 1'b0;
        last_a = '0;
        for (int i = 0; i < 16; i++) rd_cyc[i] = -100;
        while (!cmdReady && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmdReady) begin
            checks++;
            errors++;
            $display("FAIL %s.cmd_wait: cmdReady got 0, expected 1", tag);
            return;
        end
        if (wr) begin
            for (int i = 0; i < beats; i++) begin
                ea = addr + 16'(i);
                ref_mem[ea] = wbase + wstep * 16'(i);
            end
        end
        cmdValid = 1'b1;
        cmdWrite = wr;
        cmdAddr  = addr;
        cmdLen   = len;
        @(negedge clk);
        cmdValid = 1'b0;
        for (cyc = 0; cyc < 80; cyc++) begin
            if (memRead) begin
                ea = addr + 16'(nr);
                chk($sformatf("%s.rd_addr%0d", tag, nr), addrBus, ea);
                if (nr < 16) rd_cyc[nr] = cyc;
                nr++;
                last_a = addrBus;
            end
            if (memWrite) begin
                ea = addr + 16'(nw);
                ev = wbase + wstep * 16'(nw);
                chk($sformatf("%s.wr_addr%0d", tag, nw), addrBus, ea);
                chk($sformatf("%s.wr_data%0d", tag, nw), dataBus, ev);
                nw++;
                last_a = addrBus;
            end
            if (rdValid) begin
                ea = addr + 16'(nrv);
                chk($sformatf("%s.rd_data%0d", tag, nrv), rdData, ref_mem[ea]);
                if (nrv < 16)
                    chk($sformatf("%s.rd_lat%0d", tag, nrv),
                        cyc - rd_cyc[nrv], 2);
                nrv++;
            end
            if (!busy) begin
                done = 1'b1;
                break;
            end
            wdValid = 1'b0;
            if (wdReady && sent < beats) begin
                wdValid = (k < 32) ? !bmask[k] : 1'b1;
                wdData  = wbase + wstep * 16'(sent);
                if (wdValid) sent++;
                k++;
            end
            @(negedge clk);
        end
        wdValid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: busy got 1 after 80 cycles, expected 0",
                     tag);
        end else begin
            chk($sformatf("%s.busy_cycles", tag), cyc, exp_busy);
            chk($sformatf("%s.strobes", tag), wr ? nw : nr, beats);
            if (!wr) chk($sformatf("%s.rd_pulses", tag), nrv, beats);
            chk($sformatf("%s.last_addr", tag), last_a, exp_last);
            chk($sformatf("%s.cmd_ready", tag), cmdReady, 1);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [3:0]  len;
        logic [31:0] bmask;
        logic [15:0] wbase;
        logic [15:0] wstep;
        int          exp_busy;
        logic [15:0] exp_last;
    } vec_t;

    vec_t vecs [8];

    initial begin
        bit          r_wr;
        logic [15:0] r_addr, r_base, r_step;
        logic [3:0]  r_len;
        logic [31:0] r_mask;
        int          r_busy, hits;

        reset = 1'b1;
        cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = '0; cmdLen = '0;
        wdValid = 1'b0; wdData = '0;
        for (int a = 0; a < 65536; a++) begin
            mem[a]     = 16'(a) ^ 16'h5A5A;
            ref_mem[a] = 16'(a) ^ 16'h5A5A;
        end
        for (int i = 0; i < 4; i++) begin
            mem[16'h0010 + i]     = 16'h00A0 + 16'(i);
            ref_mem[16'h0010 + i] = 16'h00A0 + 16'(i);
        end

        vecs[0] = '{1'b1, 16'h1FFE, 4'd3,  32'h0,   16'h0011, 16'h0011, 5,  16'h2001};
        vecs[1] = '{1'b0, 16'h1FFE, 4'd3,  32'h0,   16'h0,    16'h0,    5,  16'h2001};
        vecs[2] = '{1'b1, 16'h0100, 4'd2,  32'h2,   16'h0C00, 16'h0101, 5,  16'h0102};
        vecs[3] = '{1'b0, 16'h0010, 4'd3,  32'h0,   16'h0,    16'h0,    5,  16'h0013};
        vecs[4] = '{1'b0, 16'hFFFF, 4'd1,  32'h0,   16'h0,    16'h0,    3,  16'h0000};
        vecs[5] = '{1'b0, 16'h0100, 4'd2,  32'h0,   16'h0,    16'h0,    4,  16'h0102};
        vecs[6] = '{1'b1, 16'hFFFE, 4'd15, 32'h241, 16'hBEEF, 16'h0003, 20, 16'h000D};
        vecs[7] = '{1'b0, 16'hFFFE, 4'd15, 32'h0,   16'h0,    16'h0,    17, 16'h000D};

        repeat (3) @(negedge clk);
        chk("rst.memRead",  memRead,  0);
        chk("rst.memWrite", memWrite, 0);
        chk("rst.addrBus",  addrBus,  0);
        chk("rst.rdValid",  rdValid,  0);
        chk("rst.rdData",   rdData,   0);
        chk("rst.wdReady",  wdReady,  0);
        chk("rst.busy",     busy,     0);
        chk("rst.cmdReady", cmdReady, 1);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_burst($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr,
                      vecs[i].len, vecs[i].bmask, vecs[i].wbase,
                      vecs[i].wstep, vecs[i].exp_busy, vecs[i].exp_last);
        end

        // Abort a len=7 read on its 3rd beat; a command offered meanwhile
        // must be ignored.
        cmdValid = 1'b1; cmdWrite = 1'b0; cmdAddr = 16'h0400; cmdLen = 4'd7;
        @(negedge clk);
        cmdWrite = 1'b1;
        chk("abort.cmd_ignored", cmdReady, 0);
        chk("abort.beat1_rd", memRead, 1);
        @(negedge clk);
        @(negedge clk);
        chk("abort.beat1_valid", rdValid, 1);
        chk("abort.beat1_data", rdData, ref_mem[16'h0400]);
        reset = 1'b1;
        cmdValid = 1'b0;
        @(negedge clk);
        chk("abort.memRead", memRead, 0);
        chk("abort.busy", busy, 0);
        chk("abort.cmdReady", cmdReady, 1);
        chk("abort.rdValid", rdValid, 0);
        chk("abort.addrBus", addrBus, 0);
        reset = 1'b0;
        hits = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rdValid || memWrite || memRead || busy) hits++;
        end
        chk("abort.quiet_after", hits, 0);

        for (int i = 0; i < 24; i++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = ($urandom_range(0, 3) == 0)
                     ? 16'hFFF0 + 16'($urandom_range(0, 15))
                     : 16'($urandom);
            r_len  = 4'($urandom);
            r_mask = $urandom & $urandom & $urandom;
            r_base = 16'($urandom);
            r_step = 16'($urandom_range(1, 255));
            r_busy = r_wr ? exp_bubbles(r_mask, int'(r_len) + 1)
                            + int'(r_len) + 2
                          : int'(r_len) + 2;
            run_burst($sformatf("rnd%0d", i), r_wr, r_addr, r_len, r_mask,
                      r_base, r_step, r_busy, r_addr + 16'(r_len));
        end

        chk("bus.violations", bus_viol, 0);
        chk("bus.rd_wr_gap_ge2", (min_gap >= 2) ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
